// File: rtl/player_health.sv
// Player health tracker: damage/heal arbitration, post-hit invulnerability,
// frame-timed delayed regeneration and death reporting for the blood bar.
module player_health #(
    parameter int MAX_BLOOD     = 100,
    parameter int INVULN_FRAMES = 30,
    parameter int REGEN_DELAY   = 120,
    parameter int REGEN_PERIOD  = 20,
    parameter int REGEN_STEP    = 1
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       Frame_Tick,
    input  logic       Game_Restart,
    input  logic       Hit_Req,
    input  logic [6:0] Hit_Damage,
    input  logic       Heal_Req,
    input  logic [6:0] Heal_Amount,
    output logic [9:0] Player_Blood,
    output logic       Is_Dead,
    output logic       Invuln,
    output logic       Hit_Ack
);

    localparam int IW = $clog2(INVULN_FRAMES + 1);
    localparam int DW = (REGEN_DELAY < 1) ? 1 : $clog2(REGEN_DELAY + 1);
    localparam int PW = $clog2(REGEN_PERIOD + 1);

    localparam logic [9:0]    BLOOD_FULL  = 10'(MAX_BLOOD);
    localparam logic [IW-1:0] INVULN_LOAD = IW'(INVULN_FRAMES);
    localparam logic [DW-1:0] DELAY_DONE  = DW'(REGEN_DELAY);
    localparam logic [PW-1:0] PERIOD_LAST = PW'(REGEN_PERIOD - 1);

    typedef enum logic [1:0] {
        ST_ALIVE,
        ST_INVULN,
        ST_DEAD
    } state_t;

    state_t        state_reg, state_next;
    logic [9:0]    blood_reg, blood_next;
    logic [IW-1:0] invuln_cnt_reg, invuln_cnt_next;
    logic [DW-1:0] delay_cnt_reg, delay_cnt_next;
    logic [PW-1:0] period_cnt_reg, period_cnt_next;
    logic          hit_ack_reg, hit_ack_next;
    logic          is_dead_reg, invuln_reg;

    logic          hit_accept;
    logic          regen_fire;
    logic [10:0]   hit_diff;
    logic [11:0]   gain_sum;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_reg      <= ST_ALIVE;
            blood_reg      <= BLOOD_FULL;
            invuln_cnt_reg <= '0;
            delay_cnt_reg  <= '0;
            period_cnt_reg <= '0;
            hit_ack_reg    <= 1'b0;
            is_dead_reg    <= 1'b0;
            invuln_reg     <= 1'b0;
        end else begin
            state_reg      <= state_next;
            blood_reg      <= blood_next;
            invuln_cnt_reg <= invuln_cnt_next;
            delay_cnt_reg  <= delay_cnt_next;
            period_cnt_reg <= period_cnt_next;
            hit_ack_reg    <= hit_ack_next;
            is_dead_reg    <= (state_next == ST_DEAD);
            invuln_reg     <= (state_next == ST_INVULN);
        end
    end

    always_comb begin
        state_next      = state_reg;
        blood_next      = blood_reg;
        invuln_cnt_next = invuln_cnt_reg;
        delay_cnt_next  = delay_cnt_reg;
        period_cnt_next = period_cnt_reg;
        hit_ack_next    = 1'b0;
        regen_fire      = 1'b0;
        hit_accept      = Hit_Req && (state_reg == ST_ALIVE);
        hit_diff        = {1'b0, blood_reg} - {4'b0, Hit_Damage};
        gain_sum        = '0;

        if (Game_Restart) begin
            state_next      = ST_ALIVE;
            blood_next      = BLOOD_FULL;
            invuln_cnt_next = '0;
            delay_cnt_next  = '0;
            period_cnt_next = '0;
        end else if (state_reg == ST_DEAD) begin
            blood_next = '0;
        end else if (hit_accept) begin
            // Borrow out of the 11-bit difference means the hit overkills.
            blood_next      = hit_diff[10] ? 10'd0 : hit_diff[9:0];
            hit_ack_next    = 1'b1;
            delay_cnt_next  = '0;
            period_cnt_next = '0;
            if (blood_next == 10'd0) begin
                state_next = ST_DEAD;
            end else begin
                state_next      = ST_INVULN;
                invuln_cnt_next = INVULN_LOAD;
            end
        end else begin
            if (Frame_Tick && state_reg == ST_INVULN) begin
                invuln_cnt_next = invuln_cnt_reg - 1'b1;
                if (invuln_cnt_reg <= IW'(1)) begin
                    state_next = ST_ALIVE;
                end
            end
            if (Frame_Tick && state_reg == ST_ALIVE) begin
                if (delay_cnt_reg != DELAY_DONE) begin
                    delay_cnt_next = delay_cnt_reg + 1'b1;
                end else if (period_cnt_reg == PERIOD_LAST) begin
                    period_cnt_next = '0;
                    regen_fire      = 1'b1;
                end else begin
                    period_cnt_next = period_cnt_reg + 1'b1;
                end
            end
            // Heal and a regen step landing together share one saturating add.
            gain_sum = {2'b00, blood_reg}
                     + (Heal_Req   ? {5'b0, Heal_Amount} : 12'd0)
                     + (regen_fire ? 12'(REGEN_STEP)     : 12'd0);
            blood_next = (gain_sum > {2'b00, BLOOD_FULL}) ? BLOOD_FULL : gain_sum[9:0];
        end
    end

    assign Player_Blood = blood_reg;
    assign Is_Dead      = is_dead_reg;
    assign Invuln       = invuln_reg;
    assign Hit_Ack      = hit_ack_reg;

endmodule

// File: doc/player_health.md
Name: player_health

Overview:
- Owns the player's health value and produces the 10-bit Player_Blood consumed by the on-screen blood bar renderer, which draws width Player_Blood[9:1] and so is full at 100.
- Accepts damage requests from zombie-collision logic and heal requests from pickup logic.
- Applies post-hit invulnerability and delayed regeneration, timed in frames.
- Reports death to the game-state controller.

Parameters:
- MAX_BLOOD, 100, full health value and restart value. Legal range 1..1023; 100 gives a full 50-pixel bar.
- INVULN_FRAMES, 30, frames of invulnerability after an accepted hit. Must be ≥1.
- REGEN_DELAY, 120, frames without an accepted hit before regeneration starts.
- REGEN_PERIOD, 20, frames between regeneration steps once regen is active. Must be ≥1.
- REGEN_STEP, 1, health added per regeneration step.

Ports:
- Clk  input  1  system clock
- Reset_n  input  1  asynchronous active-low reset
- Frame_Tick  input  1  one-Clk pulse per video frame
- Game_Restart  input  1  one-Clk pulse; restores full health from any state
- Hit_Req  input  1  damage request, sampled every Clk
- Hit_Damage  input  7  damage amount, valid with Hit_Req
- Heal_Req  input  1  heal request, sampled every Clk
- Heal_Amount  input  7  heal amount, valid with Heal_Req
- Player_Blood  output  10  current health (registered)
- Is_Dead  output  1  high while in DEAD
- Invuln  output  1  high while in INVULN
- Hit_Ack  output  1  one-Clk pulse, the cycle after a hit is accepted

Behaviour:
- Interfaces: one clock; reset is asynchronous and active-low (Clk, Reset_n). All outputs are registered.
- Reset values: Player_Blood = MAX_BLOOD; state = ALIVE; Is_Dead = 0; Invuln = 0; Hit_Ack = 0; all counters = 0.
- Reset mid-operation: reset asserted in any state returns immediately to the reset values.
- States: ALIVE, INVULN, DEAD.
- Priority per cycle:
  - 1. Game_Restart
  - 2. accepted hit
  - 3. heal
  - 4. Frame_Tick-driven counters
- Game_Restart (any state): next cycle Player_Blood = MAX_BLOOD, state = ALIVE, all counters cleared, Hit_Ack = 0. A Hit_Req or Heal_Req in the same cycle is dropped.
- Hit in ALIVE: accepted.
  - nb = Player_Blood − Hit_Damage, saturating at 0 (compute at 11 bits, clamp).
  - Player_Blood ← nb; Hit_Ack = 1 the next cycle for exactly 1 cycle.
  - Regen-delay counter and regen-period counter ← 0.
  - If nb == 0: → DEAD. Otherwise → INVULN with invuln counter ← INVULN_FRAMES.
  - Hit_Damage = 0 is still accepted: acks, enters INVULN, resets regen.
- Hit in INVULN or DEAD: ignored; no ack, no change.
- Heal in ALIVE or INVULN, with no accepted hit that cycle:
  - Player_Blood ← min(Player_Blood + Heal_Amount, MAX_BLOOD), computed at 11 bits.
  - Regen counters are not affected.
- Heal in DEAD, or in the same cycle as an accepted hit: dropped.
- INVULN exit: on each Frame_Tick the invuln counter decrements. The tick that takes it from 1 to 0 moves the state to ALIVE on the next cycle. Invuln follows the state.
- Regeneration (ALIVE only; counters hold in INVULN):
  - On each Frame_Tick, the regen-delay counter increments, saturating at REGEN_DELAY.
  - Once it equals REGEN_DELAY, each Frame_Tick increments the period counter.
  - When the period counter reaches REGEN_PERIOD, it resets to 0 and Player_Blood ← min(Player_Blood + REGEN_STEP, MAX_BLOOD).
  - Regen at full health leaves Player_Blood unchanged.
- Regen step and heal in the same cycle: both amounts are added in one saturating sum.
- Frame_Tick in the same cycle as an accepted hit: the hit wins; counters are cleared, not incremented.
- DEAD: Player_Blood = 0, Is_Dead = 1. All hits, heals and ticks are ignored; only Game_Restart exits.

Test Plan:
- Reset released, no stimulus → Player_Blood = 100, Is_Dead = 0, Invuln = 0, Hit_Ack = 0.
- ALIVE at 100; Hit_Req, Hit_Damage = 30 → next cycle Player_Blood = 70, Hit_Ack = 1 for 1 cycle, Invuln = 1. A second hit of 30 during INVULN → Player_Blood stays 70, no ack. After 30 Frame_Ticks → Invuln = 0.
- Player_Blood = 20; Hit_Damage = 50 → Player_Blood = 0, Is_Dead = 1. Then Heal_Req 40 and 200 Frame_Ticks → still 0. Then Game_Restart → 100, Is_Dead = 0.
- Player_Blood = 90; Heal_Amount = 25 → 100 (saturated). Same-cycle Hit_Damage 10 + Heal 25 from 90 in ALIVE → 80, heal dropped.
- Player_Blood = 70, ALIVE, no hits → unchanged for 139 Frame_Ticks; 71 after the 140th; 72 after the 160th. A hit of 1 at that point → 71, and regen restarts only after a further 120 + 20 frames counted in ALIVE.
- Assert Reset_n low mid-INVULN with Player_Blood = 40 → outputs asynchronously return to 100 / ALIVE / Invuln = 0.
